// File: rtl/axi_master_cmd_arbiter.sv
// Round-robin arbiter that lets NUM_REQ requesters share one AXI_master command port,
// issuing a single-cycle go per grant and returning per-requester done/error pulses.
module axi_master_cmd_arbiter #(
    parameter int NUM_REQ      = 4,
    parameter int DATA_WIDTH   = 32,
    parameter int BUSY_TIMEOUT = 64
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [NUM_REQ-1:0]            req,
    input  logic [NUM_REQ-1:0]            req_rnw,
    input  logic [32*NUM_REQ-1:0]         req_address,
    input  logic [8*NUM_REQ-1:0]          req_burst_length,
    input  logic [7*NUM_REQ-1:0]          req_burst_size,
    input  logic [NUM_REQ-1:0]            req_increment,
    input  logic [DATA_WIDTH*NUM_REQ-1:0] req_write_data,
    input  logic [NUM_REQ-1:0]            req_write_fifo_en,
    input  logic [NUM_REQ-1:0]            req_read_fifo_en,
    output logic [NUM_REQ-1:0]            grant,
    output logic [NUM_REQ-1:0]            req_done,
    output logic [NUM_REQ-1:0]            req_error,
    output logic                          go,
    output logic                          RNW,
    output logic [31:0]                   address,
    output logic [7:0]                    burst_length,
    output logic [6:0]                    burst_size,
    output logic                          increment_burst,
    output logic [DATA_WIDTH-1:0]         write_data,
    output logic                          write_fifo_en,
    output logic                          read_fifo_en,
    input  logic                          busy,
    input  logic                          done,
    input  logic                          error
);

    localparam int PW = $clog2(NUM_REQ);
    localparam int CW = $clog2(BUSY_TIMEOUT + 1);

    localparam logic [2:0] S_IDLE      = 3'd0;
    localparam logic [2:0] S_ISSUE     = 3'd1;
    localparam logic [2:0] S_WAIT_BUSY = 3'd2;
    localparam logic [2:0] S_WAIT_DONE = 3'd3;
    localparam logic [2:0] S_COMPLETE  = 3'd4;

    logic [2:0]         r_state;
    logic [PW-1:0]      r_rr;
    logic [PW-1:0]      r_owner;
    logic [NUM_REQ-1:0] r_grant;
    logic [CW-1:0]      r_cnt;
    logic               r_err;
    logic               r_rnw;
    logic [31:0]        r_addr;
    logic [7:0]         r_len;
    logic [6:0]         r_size;
    logic               r_inc;

    logic               w_any;
    logic [PW-1:0]      w_sel;
    logic [PW-1:0]      w_idx;

    // Scan downward so the candidate closest to the pointer is the last one written.
    always_comb begin
        w_any = 1'b0;
        w_sel = '0;
        w_idx = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            w_idx = PW'((int'(r_rr) + k) % NUM_REQ);
            if (req[w_idx]) begin
                w_any = 1'b1;
                w_sel = w_idx;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_rr    <= '0;
            r_owner <= '0;
            r_grant <= '0;
            r_cnt   <= '0;
            r_err   <= 1'b0;
            r_rnw   <= 1'b0;
            r_addr  <= '0;
            r_len   <= '0;
            r_size  <= '0;
            r_inc   <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_any) begin
                        r_grant <= NUM_REQ'(1) << w_sel;
                        r_owner <= w_sel;
                        r_rnw   <= req_rnw[w_sel];
                        r_addr  <= req_address[w_sel*32 +: 32];
                        r_len   <= req_burst_length[w_sel*8 +: 8];
                        r_size  <= req_burst_size[w_sel*7 +: 7];
                        r_inc   <= req_increment[w_sel];
                        r_state <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    r_cnt   <= '0;
                    r_err   <= 1'b0;
                    r_state <= S_WAIT_BUSY;
                end
                S_WAIT_BUSY: begin
                    if (done) begin
                        r_err   <= error;
                        r_state <= S_COMPLETE;
                    end else if (busy) begin
                        r_state <= S_WAIT_DONE;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                        if (r_cnt == CW'(BUSY_TIMEOUT - 1)) begin
                            r_err   <= 1'b1;
                            r_state <= S_COMPLETE;
                        end
                    end
                end
                S_WAIT_DONE: begin
                    if (done) begin
                        r_err   <= error;
                        r_state <= S_COMPLETE;
                    end
                end
                S_COMPLETE: begin
                    r_grant <= '0;
                    r_rr    <= (r_owner == PW'(NUM_REQ - 1)) ? '0 : r_owner + 1'b1;
                    r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign grant           = r_grant;
    assign go              = (r_state == S_ISSUE);
    assign req_done        = (r_state == S_COMPLETE) ? r_grant : '0;
    assign req_error       = ((r_state == S_COMPLETE) && (r_err || error)) ? r_grant : '0;
    assign RNW             = r_rnw;
    assign address         = r_addr;
    assign burst_length    = r_len;
    assign burst_size      = r_size;
    assign increment_burst = r_inc;

    // FIFO strobes follow the owner only; an idle arbiter drives zeros.
    always_comb begin
        write_data    = '0;
        write_fifo_en = 1'b0;
        read_fifo_en  = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (r_grant[i]) begin
                write_data    = req_write_data[i*DATA_WIDTH +: DATA_WIDTH];
                write_fifo_en = req_write_fifo_en[i];
                read_fifo_en  = req_read_fifo_en[i];
            end
        end
    end

endmodule

// File: tb/tb_axi_master_cmd_arbiter.sv
// Directed and randomized bench for axi_master_cmd_arbiter, acting as requesters and
// AXI_master, with a transaction-level round-robin model.
module tb_axi_master_cmd_arbiter;

    localparam int N  = 4;
    localparam int DW = 32;
    localparam int TO = 64;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    logic [N-1:0]      req, req_rnw, req_increment, req_write_fifo_en, req_read_fifo_en;
    logic [32*N-1:0]   req_address;
    logic [8*N-1:0]    req_burst_length;
    logic [7*N-1:0]    req_burst_size;
    logic [DW*N-1:0]   req_write_data;
    logic [N-1:0]      grant, req_done, req_error;
    logic              go, RNW, increment_burst, write_fifo_en, read_fifo_en;
    logic [31:0]       address;
    logic [7:0]        burst_length;
    logic [6:0]        burst_size;
    logic [DW-1:0]     write_data;
    logic              busy, done, error;

    logic [31:0]       f_addr [N];
    logic [7:0]        f_len  [N];
    logic [6:0]        f_size [N];
    logic [DW-1:0]     f_wd   [N];

    for (genvar g = 0; g < N; g++) begin : g_pack
        assign req_address[32*g +: 32]    = f_addr[g];
        assign req_burst_length[8*g +: 8] = f_len[g];
        assign req_burst_size[7*g +: 7]   = f_size[g];
        assign req_write_data[DW*g +: DW] = f_wd[g];
    end

    axi_master_cmd_arbiter #(.NUM_REQ(N), .DATA_WIDTH(DW), .BUSY_TIMEOUT(TO)) dut (
        .clk(clk), .reset(reset), .req(req), .req_rnw(req_rnw),
        .req_address(req_address), .req_burst_length(req_burst_length),
        .req_burst_size(req_burst_size), .req_increment(req_increment),
        .req_write_data(req_write_data), .req_write_fifo_en(req_write_fifo_en),
        .req_read_fifo_en(req_read_fifo_en), .grant(grant), .req_done(req_done),
        .req_error(req_error), .go(go), .RNW(RNW), .address(address),
        .burst_length(burst_length), .burst_size(burst_size),
        .increment_burst(increment_burst), .write_data(write_data),
        .write_fifo_en(write_fifo_en), .read_fifo_en(read_fifo_en),
        .busy(busy), .done(done), .error(error)
    );

    int checks = 0;
    int fails  = 0;
    int m_rr   = 0;
    logic [N-1:0] exp_q[$];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    function automatic int pick(input logic [N-1:0] m, input int rr);
        for (int k = 0; k < N; k++) if (m[(rr + k) % N]) return (rr + k) % N;
        return 0;
    endfunction

    task automatic rand_fields();
        for (int i = 0; i < N; i++) begin
            f_addr[i] = $urandom;
            f_len[i]  = 8'($urandom_range(0, 255));
            f_size[i] = 7'($urandom_range(0, 127));
            f_wd[i]   = $urandom;
        end
        req_rnw       = N'($urandom);
        req_increment = N'($urandom);
    endtask

    task automatic apply_reset();
        reset = 1'b1;
        step();
        step();
        reset = 1'b0;
        m_rr  = 0;
    endtask

    // Called at a negedge with the arbiter idle; runs one whole transaction for `own`.
    task automatic do_txn(input int own, input int bd, input int dd, input bit err,
                          input bit tmo, input bit drop);
        logic [31:0] ea;
        logic [7:0]  el;
        logic [6:0]  es;
        logic        er, ei;
        int          n;
        ea = f_addr[own]; el = f_len[own]; es = f_size[own];
        er = req_rnw[own]; ei = req_increment[own];
        busy = 1'b0; done = 1'b0; error = 1'b0;
        step();
        chk("grant", grant, N'(1) << own);
        chk("go_pulse", go, 1);
        chk("address", address, ea);
        chk("burst_length", burst_length, el);
        chk("burst_size", burst_size, es);
        chk("rnw", RNW, er);
        chk("increment", increment_burst, ei);
        req_write_fifo_en = N'($urandom);
        req_read_fifo_en  = N'($urandom);
        #1;
        chk("wfifo_route", write_fifo_en, req_write_fifo_en[own]);
        chk("rfifo_route", read_fifo_en, req_read_fifo_en[own]);
        chk("wdata_route", write_data, f_wd[own]);
        if (drop) req[own] = 1'b0;
        rand_fields();
        done  = 1'($urandom_range(0, 1));
        error = done;
        step();
        done = 1'b0; error = 1'b0;
        chk("go_single", go, 0);
        chk("done_ignored_issue", req_done, 0);
        chk("address_hold", address, ea);
        if (tmo) begin
            n = 1;
            while (req_done == '0 && n < 100) begin
                step();
                n++;
            end
            chk("timeout_cycles", n, TO + 1);
        end else begin
            repeat (bd) begin
                step();
                chk("go_low_wait", go, 0);
            end
            busy = 1'b1;
            repeat (dd) begin
                step();
                chk("go_low_busy", go, 0);
                chk("grant_hold", grant, N'(1) << own);
            end
            done = 1'b1; error = err;
            step();
            done = 1'b0; error = 1'b0; busy = 1'b0;
        end
        chk("req_done", req_done, N'(1) << own);
        chk("req_error", req_error, (err | tmo) ? (N'(1) << own) : 0);
        chk("len_hold", burst_length, el);
        step();
        chk("grant_released", grant, 0);
        chk("done_one_cycle", req_done, 0);
        chk("wfifo_idle", write_fifo_en, 0);
        m_rr = (own + 1) % N;
    endtask

    initial begin
        int own;
        reset = 1'b1;
        req = '0; req_write_fifo_en = '0; req_read_fifo_en = '0;
        busy = 1'b0; done = 1'b0; error = 1'b0;
        rand_fields();
        @(negedge clk);
        chk("rst_grant", grant, 0);
        chk("rst_go", go, 0);
        chk("rst_done", req_done, 0);
        chk("rst_address", address, 0);
        chk("rst_len", burst_length, 0);
        chk("rst_rnw", RNW, 0);
        apply_reset();

        // Single requester with fixed command fields.
        f_addr[1] = 32'h4000_0000; f_len[1] = 8'd8; f_size[1] = 7'd4; req_rnw[1] = 1'b0;
        req = 4'b0010;
        do_txn(1, 1, 2, 1'b0, 1'b0, 1'b0);
        req = '0;

        // A master done/error while idle must be ignored.
        done = 1'b1; error = 1'b1;
        step();
        done = 1'b0; error = 1'b0;
        chk("idle_done_ignored", req_done, 0);
        chk("idle_grant", grant, 0);

        // All requesters high from reset: strict rotation.
        apply_reset();
        exp_q = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
        req = 4'b1111;
        while (exp_q.size() > 0) begin
            own = pick(exp_q.pop_front(), 0);
            do_txn(own, $urandom_range(0, 3), $urandom_range(0, 4), 1'b0, 1'b0, 1'b0);
        end

        // Requester 2 drops req after grant; the pointer still moves past it.
        req = 4'b0100;
        do_txn(2, 0, 2, 1'b0, 1'b0, 1'b1);
        req = 4'b1111;
        do_txn(pick(req, m_rr), 0, 1, 1'b0, 1'b0, 1'b0);

        // Master silent: forced error after the busy timeout.
        req = 4'b0001;
        do_txn(pick(req, m_rr), 0, 0, 1'b0, 1'b1, 1'b0);

        // Read from requester 3 ending with error.
        req = 4'b1000;
        req_rnw[3] = 1'b1;
        do_txn(3, 1, 1, 1'b1, 1'b0, 1'b0);

        // Randomized traffic against the round-robin model.
        for (int t = 0; t < 12; t++) begin
            req = N'($urandom_range(1, 15));
            do_txn(pick(req, m_rr), $urandom_range(0, 3), $urandom_range(0, 4),
                   1'($urandom_range(0, 1)), 1'b0, 1'($urandom_range(0, 1)));
        end

        // Reset in WAIT_DONE with the pointer at 2.
        req = 4'b0010;
        do_txn(pick(req, m_rr), 0, 1, 1'b0, 1'b0, 1'b0);
        req = 4'b0100;
        f_addr[2] = 32'hdead_beef;
        step();
        chk("pre_reset_grant", grant, 4'b0100);
        busy = 1'b1;
        req_write_fifo_en = 4'b1111;
        step();
        step();
        #2 reset = 1'b1;
        #1;
        chk("async_rst_grant", grant, 0);
        chk("async_rst_go", go, 0);
        chk("async_rst_address", address, 0);
        chk("async_rst_wfifo", write_fifo_en, 0);
        chk("async_rst_done", req_done, 0);
        busy = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        m_rr  = 0;
        req   = 4'b0101;
        chk("no_done_after_abort", req_done, 0);
        do_txn(pick(req, m_rr), 0, 1, 1'b0, 1'b0, 1'b0);

        $display("%0d/%0d checks passed", checks - fails, checks);
        $finish;
    end

endmodule
